// File: rtl/id_ctrl_stall.sv
// ============================================================================
//  Module      : id_ctrl_stall
//  Description : ID-stage decode (EXTOp/NPCOp/RegWrite) plus D-stage stall
//                generation for load-use hazards and multi-cycle mult/div.
//                Optional macro IDC_DIV_EN enables div/divu decode and issue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ctrl_stall #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic [31:0] rd2_d,
    output logic [1:0]  EXTOp,
    output logic [3:0]  NPCOp,
    output logic        RegWrite,
    output logic        Stall,
    output logic        md_start,
    output logic        md_busy
);

    localparam logic [5:0] c_op_rtype  = 6'h00;
    localparam logic [5:0] c_op_regimm = 6'h01;
    localparam logic [5:0] c_op_j      = 6'h02;
    localparam logic [5:0] c_op_jal    = 6'h03;
    localparam logic [5:0] c_op_beq    = 6'h04;
    localparam logic [5:0] c_op_bne    = 6'h05;
    localparam logic [5:0] c_op_blez   = 6'h06;
    localparam logic [5:0] c_op_bgtz   = 6'h07;

    localparam logic [3:0] c_npc_pc4  = 4'd0;
    localparam logic [3:0] c_npc_beq  = 4'd1;
    localparam logic [3:0] c_npc_j    = 4'd2;
    localparam logic [3:0] c_npc_jr   = 4'd3;
    localparam logic [3:0] c_npc_jalr = 4'd4;
    localparam logic [3:0] c_npc_bne  = 4'd5;
    localparam logic [3:0] c_npc_bgtz = 4'd6;
    localparam logic [3:0] c_npc_blez = 4'd7;
    localparam logic [3:0] c_npc_bgez = 4'd8;
    localparam logic [3:0] c_npc_bltz = 4'd9;

    localparam logic [1:0] c_ext_sign = 2'b00;
    localparam logic [1:0] c_ext_zero = 2'b01;
    localparam logic [1:0] c_ext_lui  = 2'b10;

    localparam logic [CNT_W-1:0] c_mult_lat = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_lat  = CNT_W'(DIV_CYCLES);

    logic [5:0] w_op;
    logic [5:0] w_func;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_unused_fields;

    assign w_op            = instr_d[31:26];
    assign w_rs            = instr_d[25:21];
    assign w_rt            = instr_d[20:16];
    assign w_func          = instr_d[5:0];
    assign w_unused_fields = ^instr_d[15:6];

    logic [1:0] w_ext;
    logic [3:0] w_npc;
    logic       w_rw;
    logic       w_is_load;
    logic       w_uses_rs;
    logic       w_uses_rt;
    logic       w_md_op;
    logic       w_is_div;
    logic       w_md_use;

    always_comb begin
        w_ext     = c_ext_sign;
        w_npc     = c_npc_pc4;
        w_rw      = 1'b0;
        w_is_load = 1'b0;
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        w_md_op   = 1'b0;
        w_is_div  = 1'b0;
        w_md_use  = 1'b0;
        case (w_op)
            c_op_rtype: begin
                case (w_func)
                    6'h00, 6'h02, 6'h03: begin
                        w_rw      = 1'b1;
                        w_uses_rt = 1'b1;
                    end
                    6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        w_rw      = 1'b1;
                        w_uses_rs = 1'b1;
                        w_uses_rt = 1'b1;
                    end
                    6'h08: begin
                        w_npc     = c_npc_jr;
                        w_uses_rs = 1'b1;
                    end
                    6'h09: begin
                        w_npc     = c_npc_jalr;
                        w_rw      = 1'b1;
                        w_uses_rs = 1'b1;
                    end
                    6'h0A: begin
                        w_rw      = (rd2_d == 32'd0);
                        w_uses_rs = 1'b1;
                        w_uses_rt = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        w_rw     = 1'b1;
                        w_md_use = 1'b1;
                    end
                    6'h11, 6'h13: begin
                        w_uses_rs = 1'b1;
                        w_md_use  = 1'b1;
                    end
                    6'h18, 6'h19: begin
                        w_uses_rs = 1'b1;
                        w_uses_rt = 1'b1;
                        w_md_op   = 1'b1;
                        w_md_use  = 1'b1;
                    end
`ifdef IDC_DIV_EN
                    6'h1A, 6'h1B: begin
                        w_uses_rs = 1'b1;
                        w_uses_rt = 1'b1;
                        w_md_op   = 1'b1;
                        w_is_div  = 1'b1;
                        w_md_use  = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            c_op_regimm: begin
                // Unsupported rt values leave everything at the harmless defaults.
                if (w_rt == 5'b00001) begin
                    w_npc     = c_npc_bgez;
                    w_uses_rs = 1'b1;
                end else if (w_rt == 5'b00000) begin
                    w_npc     = c_npc_bltz;
                    w_uses_rs = 1'b1;
                end
            end
            c_op_j:   w_npc = c_npc_j;
            c_op_jal: begin
                w_npc = c_npc_j;
                w_rw  = 1'b1;
            end
            c_op_beq, c_op_bne: begin
                w_npc     = (w_op == c_op_beq) ? c_npc_beq : c_npc_bne;
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            c_op_blez, c_op_bgtz: begin
                w_npc     = (w_op == c_op_blez) ? c_npc_blez : c_npc_bgtz;
                w_uses_rs = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                w_rw      = 1'b1;
                w_uses_rs = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_ext     = c_ext_zero;
                w_rw      = 1'b1;
                w_uses_rs = 1'b1;
            end
            6'h0F: begin
                w_ext = c_ext_lui;
                w_rw  = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                w_rw      = 1'b1;
                w_is_load = 1'b1;
                w_uses_rs = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

    logic             r_load_e_q;
    logic             r_load_e_d;
    logic [4:0]       r_dst_e_q;
    logic [4:0]       r_dst_e_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] r_cnt_d;
    logic             r_md_start_q;
    logic             r_md_start_d;

    logic w_load_use;
    logic w_md_stall;
    logic w_stall;
    logic w_issue;

    assign w_load_use = r_load_e_q && (r_dst_e_q != 5'd0) &&
                        ((w_uses_rs && (w_rs == r_dst_e_q)) ||
                         (w_uses_rt && (w_rt == r_dst_e_q)));
    assign w_md_stall = w_md_use && (r_cnt_q != '0);
    assign w_stall    = w_load_use || w_md_stall;
    assign w_issue    = w_md_op && !w_stall;

    always_comb begin
        r_load_e_d   = 1'b0;
        r_dst_e_d    = r_dst_e_q;
        r_md_start_d = w_issue;
        if (!w_stall) begin
            r_load_e_d = w_is_load;
            r_dst_e_d  = w_rt;
        end
        if (w_issue) begin
            r_cnt_d = w_is_div ? c_div_lat : c_mult_lat;
        end else if (r_cnt_q != '0) begin
            r_cnt_d = r_cnt_q - 1'b1;
        end else begin
            r_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_e_q   <= 1'b0;
            r_dst_e_q    <= 5'd0;
            r_cnt_q      <= '0;
            r_md_start_q <= 1'b0;
        end else begin
            r_load_e_q   <= r_load_e_d;
            r_dst_e_q    <= r_dst_e_d;
            r_cnt_q      <= r_cnt_d;
            r_md_start_q <= r_md_start_d;
        end
    end

    // A stalled instruction must not redirect fetch or commit a write.
    assign EXTOp    = w_ext;
    assign NPCOp    = w_stall ? c_npc_pc4 : w_npc;
    assign RegWrite = w_rw && !w_stall;
    assign Stall    = w_stall;
    assign md_start = r_md_start_q;
    assign md_busy  = (r_cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_id_ctrl_stall.sv
// ============================================================================
//  Module      : tb_id_ctrl_stall
//  Description : Directed self-checking bench for id_ctrl_stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ctrl_stall;

    logic        clk;
    logic        reset;
    logic [31:0] instr_d;
    logic [31:0] rd2_d;
    logic [1:0]  EXTOp;
    logic [3:0]  NPCOp;
    logic        RegWrite;
    logic        Stall;
    logic        md_start;
    logic        md_busy;

    int checks;
    int failures;

    id_ctrl_stall #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .instr_d (instr_d),
        .rd2_d   (rd2_d),
        .EXTOp   (EXTOp),
        .NPCOp   (NPCOp),
        .RegWrite(RegWrite),
        .Stall   (Stall),
        .md_start(md_start),
        .md_busy (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a new D-stage instruction just after a rising edge and
    // return mid-cycle so combinational and registered outputs are settled.
    task automatic drive(input logic [31:0] ins, input logic [31:0] rd2);
        @(posedge clk);
        #1;
        instr_d = ins;
        rd2_d   = rd2;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        instr_d  = 32'd0;
        rd2_d    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        instr_d = rtype(1, 2, 3, 'h21);
        @(negedge clk);
        check("rst_stall",    32'(Stall),    32'd0);
        check("rst_md_busy",  32'(md_busy),  32'd0);
        check("rst_md_start", 32'(md_start), 32'd0);
        check("addu_rw",      32'(RegWrite), 32'd1);
        check("addu_npc",     32'(NPCOp),    32'd0);
        check("addu_ext",     32'(EXTOp),    32'd0);

        // load-use on rs
        drive(itype('h23, 1, 8, 0), 0);
        check("lw_rw",    32'(RegWrite), 32'd1);
        check("lw_stall", 32'(Stall),    32'd0);
        drive(rtype(8, 1, 9, 'h21), 0);
        check("lu_stall", 32'(Stall),    32'd1);
        check("lu_rw",    32'(RegWrite), 32'd0);
        drive(rtype(8, 1, 9, 'h21), 0);
        check("lu_proceed_stall", 32'(Stall),    32'd0);
        check("lu_proceed_rw",    32'(RegWrite), 32'd1);

        // load to $0 never stalls
        drive(itype('h23, 1, 0, 0), 0);
        drive(rtype(0, 0, 9, 'h21), 0);
        check("lw0_stall", 32'(Stall), 32'd0);

        // load-use via rt on a store
        drive(itype('h23, 1, 8, 0), 0);
        drive(itype('h2B, 2, 8, 4), 0);
        check("sw_rt_stall", 32'(Stall), 32'd1);
        drive(itype('h2B, 2, 8, 4), 0);
        check("sw_proceed", 32'(Stall), 32'd0);

        // beq gated to pc+4 while stalled, then branches
        drive(itype('h23, 1, 8, 0), 0);
        drive(itype('h04, 8, 3, 2), 0);
        check("beq_stall",     32'(Stall), 32'd1);
        check("beq_stall_npc", 32'(NPCOp), 32'd0);
        drive(itype('h04, 8, 3, 2), 0);
        check("beq_npc", 32'(NPCOp), 32'd1);

        // EXTOp kept during a stall
        drive(itype('h23, 1, 8, 0), 0);
        drive(itype('h0D, 8, 9, 5), 0);
        check("ori_stall_stall", 32'(Stall), 32'd1);
        check("ori_stall_ext",   32'(EXTOp), 32'd1);

        // mult then mflo: busy 5 cycles
        drive(rtype(1, 2, 0, 'h18), 0);
        check("mult_stall", 32'(Stall),    32'd0);
        check("mult_rw",    32'(RegWrite), 32'd0);
        drive(rtype(0, 0, 5, 'h12), 0);
        check("md_start_t1", 32'(md_start), 32'd1);
        check("md_busy_t1",  32'(md_busy),  32'd1);
        check("mflo_stall1", 32'(Stall),    32'd1);
        check("mflo_rw1",    32'(RegWrite), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            drive(rtype(0, 0, 5, 'h12), 0);
            check($sformatf("mflo_stall%0d", k), 32'(Stall), 32'd1);
            check($sformatf("md_start%0d", k), 32'(md_start), 32'd0);
        end
        drive(rtype(0, 0, 5, 'h12), 0);
        check("mflo_go_stall", 32'(Stall),    32'd0);
        check("mflo_go_rw",    32'(RegWrite), 32'd1);
        check("mflo_go_busy",  32'(md_busy),  32'd0);
        drive(rtype(1, 2, 3, 'h21), 0);
        check("mflo_no_start", 32'(md_start), 32'd0);

`ifdef IDC_DIV_EN
        drive(rtype(1, 2, 0, 'h1A), 0);
        check("div_stall", 32'(Stall),    32'd0);
        check("div_rw",    32'(RegWrite), 32'd0);
        drive(32'd0, 0);
        check("div_start", 32'(md_start), 32'd1);
        drive(32'd0, 0);
        check("div_busy2", 32'(md_busy), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        instr_d = rtype(0, 0, 5, 'h12);
        @(negedge clk);
        check("div_rst_busy",  32'(md_busy), 32'd0);
        check("div_rst_stall", 32'(Stall),   32'd0);
`else
        drive(rtype(1, 2, 0, 'h1A), 0);
        check("div_off_rw",  32'(RegWrite), 32'd0);
        check("div_off_npc", 32'(NPCOp),    32'd0);
        drive(rtype(0, 0, 5, 'h12), 0);
        check("div_off_start", 32'(md_start), 32'd0);
        check("div_off_busy",  32'(md_busy),  32'd0);
        check("div_off_stall", 32'(Stall),    32'd0);
`endif

        // misc decode
        drive(rtype(1, 2, 3, 'h0A), 0);
        check("movz0_rw", 32'(RegWrite), 32'd1);
        drive(rtype(1, 2, 3, 'h0A), 5);
        check("movz5_rw", 32'(RegWrite), 32'd0);
        drive(itype('h01, 1, 1, 4), 0);
        check("bgez_npc", 32'(NPCOp),    32'd8);
        check("bgez_rw",  32'(RegWrite), 32'd0);
        drive(itype('h01, 1, 0, 4), 0);
        check("bltz_npc", 32'(NPCOp), 32'd9);
        drive(itype('h01, 1, 2, 4), 0);
        check("regimm_bad_npc", 32'(NPCOp), 32'd0);
        drive(itype('h0D, 1, 2, 4), 0);
        check("ori_ext", 32'(EXTOp),    32'd1);
        check("ori_rw",  32'(RegWrite), 32'd1);
        drive(itype('h0F, 0, 2, 4), 0);
        check("lui_ext", 32'(EXTOp), 32'd2);
        drive(rtype(31, 0, 0, 'h08), 0);
        check("jr_npc", 32'(NPCOp),    32'd3);
        check("jr_rw",  32'(RegWrite), 32'd0);
        drive(rtype(31, 0, 31, 'h09), 0);
        check("jalr_npc", 32'(NPCOp),    32'd4);
        check("jalr_rw",  32'(RegWrite), 32'd1);
        drive({6'h03, 26'd100}, 0);
        check("jal_npc", 32'(NPCOp),    32'd2);
        check("jal_rw",  32'(RegWrite), 32'd1);
        drive(itype('h07, 1, 0, 4), 0);
        check("bgtz_npc", 32'(NPCOp), 32'd6);
        drive(itype('h3F, 1, 2, 4), 0);
        check("unk_ext", 32'(EXTOp),    32'd0);
        check("unk_npc", 32'(NPCOp),    32'd0);
        check("unk_rw",  32'(RegWrite), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
